// File: rtl/morsecode_receiver_if.sv
`default_nettype none
// ============================================================================
// Module      : morsecode_receiver_if
// Description : Key input and decoded-letter outputs of the Morse receiver.
// Revision    : 1.0 - initial release
// ============================================================================
interface morsecode_receiver_if;
    logic       enable;
    logic       key_in;
    logic [4:0] letter;
    logic       letter_valid;
    logic       letter_err;
    logic [3:0] pattern;
    logic [2:0] pattern_len;
    logic       busy;

    modport master (
        output enable, key_in,
        input  letter, letter_valid, letter_err, pattern, pattern_len, busy
    );

    modport slave (
        input  enable, key_in,
        output letter, letter_valid, letter_err, pattern, pattern_len, busy
    );
endinterface
`default_nettype wire

// File: rtl/morsecode_receiver.sv
`default_nettype none
// ============================================================================
// Module      : morsecode_receiver
// Description : Times marks/spaces on a keyed line, classifies dot/dash and
//               strobes the decoded letter A-Z (or an error) at each letter gap.
//               Optional macro MORSE_RX_SYNC_EN adds a 2-flop key synchronizer.
// Revision    : 1.0 - initial release
// ============================================================================
module morsecode_receiver #(
    parameter int UNIT_CYCLES = 4
) (
    input  wire                 clk,
    input  wire                 rst,
    morsecode_receiver_if.slave bus
);

    localparam int c_CNT_W = $clog2(2 * UNIT_CYCLES) + 1;
    localparam logic [c_CNT_W-1:0] c_TWO_U   = c_CNT_W'(2 * UNIT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_GAP_END = c_CNT_W'(2 * UNIT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_ONE     = c_CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MARK  = 2'd1,
        S_SPACE = 2'd2
    } state_t;

    state_t              r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [3:0]          r_el;
    logic [2:0]          r_n;
    logic                r_ovf;
    logic [4:0]          r_letter;
    logic                r_valid;
    logic                r_err;
    logic [3:0]          r_pattern;
    logic [2:0]          r_pattern_len;
    logic                w_key;
    logic                w_dec_ok;
    logic [4:0]          w_dec_idx;

`ifdef MORSE_RX_SYNC_EN
    logic [1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) r_sync <= 2'b00;
        else     r_sync <= {r_sync[0], bus.key_in};
    end

    assign w_key = r_sync[1];
`else
    assign w_key = bus.key_in;
`endif

    // Table key is {element count, elements}; bit k = element k, 1 = dash.
    always_comb begin
        w_dec_ok  = 1'b1;
        w_dec_idx = 5'd0;
        case ({r_n, r_el})
            7'b010_0010: w_dec_idx = 5'd0;
            7'b100_0001: w_dec_idx = 5'd1;
            7'b100_0101: w_dec_idx = 5'd2;
            7'b011_0001: w_dec_idx = 5'd3;
            7'b001_0000: w_dec_idx = 5'd4;
            7'b100_0100: w_dec_idx = 5'd5;
            7'b011_0011: w_dec_idx = 5'd6;
            7'b100_0000: w_dec_idx = 5'd7;
            7'b010_0000: w_dec_idx = 5'd8;
            7'b100_1110: w_dec_idx = 5'd9;
            7'b011_0101: w_dec_idx = 5'd10;
            7'b100_0010: w_dec_idx = 5'd11;
            7'b010_0011: w_dec_idx = 5'd12;
            7'b010_0001: w_dec_idx = 5'd13;
            7'b011_0111: w_dec_idx = 5'd14;
            7'b100_0110: w_dec_idx = 5'd15;
            7'b100_1011: w_dec_idx = 5'd16;
            7'b011_0010: w_dec_idx = 5'd17;
            7'b011_0000: w_dec_idx = 5'd18;
            7'b001_0001: w_dec_idx = 5'd19;
            7'b011_0100: w_dec_idx = 5'd20;
            7'b100_1000: w_dec_idx = 5'd21;
            7'b011_0110: w_dec_idx = 5'd22;
            7'b100_1001: w_dec_idx = 5'd23;
            7'b100_1101: w_dec_idx = 5'd24;
            7'b100_0011: w_dec_idx = 5'd25;
            default:     w_dec_ok  = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_el          <= 4'd0;
            r_n           <= 3'd0;
            r_ovf         <= 1'b0;
            r_letter      <= 5'd0;
            r_valid       <= 1'b0;
            r_err         <= 1'b0;
            r_pattern     <= 4'd0;
            r_pattern_len <= 3'd0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            if (!bus.enable) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
                r_el    <= 4'd0;
                r_n     <= 3'd0;
                r_ovf   <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_key) begin
                            r_state <= S_MARK;
                            r_cnt   <= c_ONE;
                        end
                    end
                    S_MARK: begin
                        if (w_key) begin
                            if (r_cnt != c_TWO_U) r_cnt <= r_cnt + c_ONE;
                        end else begin
                            if (r_n < 3'd4) begin
                                r_el[r_n[1:0]] <= (r_cnt >= c_TWO_U);
                                r_n            <= r_n + 3'd1;
                            end else begin
                                r_ovf <= 1'b1;
                            end
                            r_state <= S_SPACE;
                            r_cnt   <= c_ONE;
                        end
                    end
                    S_SPACE: begin
                        if (w_key) begin
                            r_state <= S_MARK;
                            r_cnt   <= c_ONE;
                        end else if (r_cnt == c_GAP_END) begin
                            // This low sample completes the 2U letter gap.
                            r_pattern <= r_el;
                            if (r_ovf || !w_dec_ok) begin
                                r_err         <= 1'b1;
                                r_pattern_len <= r_ovf ? 3'd5 : r_n;
                            end else begin
                                r_valid       <= 1'b1;
                                r_letter      <= w_dec_idx;
                                r_pattern_len <= r_n;
                            end
                            r_state <= S_IDLE;
                            r_cnt   <= '0;
                            r_el    <= 4'd0;
                            r_n     <= 3'd0;
                            r_ovf   <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + c_ONE;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.letter       = r_letter;
    assign bus.letter_valid = r_valid;
    assign bus.letter_err   = r_err;
    assign bus.pattern      = r_pattern;
    assign bus.pattern_len  = r_pattern_len;
    assign bus.busy         = (r_state != S_IDLE);

endmodule
`default_nettype wire
